// File: rtl/pe_result_quantizer.sv
// Requantizes Winograd PE accumulator results to DATA_BIT, packs them into words, buffers in a FWFT FIFO.
// Build option QUANT_RELU_EN: clamp negatives to zero ahead of saturation.
module pe_result_quantizer #(
   parameter int unsigned OUT_BIT     = 24,
   parameter int unsigned DATA_BIT    = 8,
   parameter int unsigned X_PE        = 8,
   parameter int unsigned RESULT_SIZE = 2,
   parameter int unsigned SHIFT_BIT   = 5,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            in_valid,
   input  logic                                            poolop,
   input  logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0] in_unpool,
   input  logic [OUT_BIT*X_PE-1:0]                         in_pool,
   input  logic [SHIFT_BIT-1:0]                            shift,
   input  logic                                            flush,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [DATA_BIT*X_PE*RESULT_SIZE*RESULT_SIZE-1:0] out_data,
   output logic [$clog2(FIFO_DEPTH):0]                     fifo_level,
   output logic                                            overflow,
   output logic                                            mode_err
);

   localparam int unsigned ELEMS  = RESULT_SIZE * RESULT_SIZE;
   localparam int unsigned N_EL   = X_PE * ELEMS;
   localparam int unsigned SLOT_W = X_PE * DATA_BIT;
   localparam int unsigned WORD_W = N_EL * DATA_BIT;
   localparam int unsigned CNT_W  = $clog2(ELEMS);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   // Rounding add is done one bit wider so x + 2^(shift-1) cannot wrap.
   function automatic logic signed [OUT_BIT-1:0] requant(input logic signed [OUT_BIT-1:0] x,
                                                        input logic [SHIFT_BIT-1:0]      sh);
      logic signed [OUT_BIT:0] ext;
      logic signed [OUT_BIT:0] rnd;
      logic signed [OUT_BIT:0] sum;
      ext = {x[OUT_BIT-1], x};
      rnd = (OUT_BIT+1)'(1) << (sh - SHIFT_BIT'(1));
      sum = (ext + rnd) >>> sh;
      return (sh == '0) ? x : sum[OUT_BIT-1:0];
   endfunction

   function automatic logic [DATA_BIT-1:0] saturate(input logic signed [OUT_BIT-1:0] y);
      logic signed [OUT_BIT-1:0] hi;
      logic signed [OUT_BIT-1:0] lo;
      hi = OUT_BIT'((1 << (DATA_BIT - 1)) - 1);
      lo = ~hi;
`ifdef QUANT_RELU_EN
      if (y < 0) return '0;
`endif
      if (y > hi) return hi[DATA_BIT-1:0];
      if (y < lo) return lo[DATA_BIT-1:0];
      return y[DATA_BIT-1:0];
   endfunction

   // Stage 1: select source and requantize
   logic signed [OUT_BIT-1:0] raw [N_EL];
   logic signed [OUT_BIT-1:0] s1_val_q [N_EL];
   logic                      s1_valid_q, s1_pool_q, s1_flush_q;

   always_comb begin
      for (int i = 0; i < N_EL; i++) raw[i] = poolop ? '0 : in_unpool[i*OUT_BIT +: OUT_BIT];
      for (int c = 0; c < X_PE; c++) begin
         if (poolop) raw[c] = in_pool[c*OUT_BIT +: OUT_BIT];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_pool_q  <= 1'b0;
         s1_flush_q <= 1'b0;
         for (int i = 0; i < N_EL; i++) s1_val_q[i] <= '0;
      end else begin
         s1_valid_q <= in_valid;
         s1_pool_q  <= poolop;
         s1_flush_q <= flush;
         if (in_valid) begin
            for (int i = 0; i < N_EL; i++) s1_val_q[i] <= requant(raw[i], shift);
         end
      end
   end

   // Stage 2: saturate and pack
   logic [WORD_W-1:0] sat_word, merged;
   logic [WORD_W-1:0] pack_q, pack_d, push_data_q, push_data_d;
   logic [CNT_W-1:0]  pack_cnt_q, pack_cnt_d;
   logic              push_q, push_d, mode_err_q, mode_err_d;

   always_comb begin
      sat_word = '0;
      for (int i = 0; i < N_EL; i++) sat_word[i*DATA_BIT +: DATA_BIT] = saturate(s1_val_q[i]);
      merged = pack_q;
      merged[pack_cnt_q*SLOT_W +: SLOT_W] = sat_word[SLOT_W-1:0];
      pack_d      = pack_q;
      pack_cnt_d  = pack_cnt_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      mode_err_d  = mode_err_q;
      if (s1_valid_q && !s1_pool_q) begin
         // Unpooled beat abandons any partial pooled word.
         if (pack_cnt_q != '0) mode_err_d = 1'b1;
         push_d      = 1'b1;
         push_data_d = sat_word;
         pack_d      = '0;
         pack_cnt_d  = '0;
      end else if (s1_valid_q) begin
         if (pack_cnt_q == CNT_W'(ELEMS - 1) || s1_flush_q) begin
            push_d      = 1'b1;
            push_data_d = merged;
            pack_d      = '0;
            pack_cnt_d  = '0;
         end else begin
            pack_d     = merged;
            pack_cnt_d = pack_cnt_q + CNT_W'(1);
         end
      end else if (s1_flush_q && pack_cnt_q != '0) begin
         push_d      = 1'b1;
         push_data_d = pack_q;
         pack_d      = '0;
         pack_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_q      <= '0;
         pack_cnt_q  <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         mode_err_q  <= 1'b0;
      end else begin
         pack_q      <= pack_d;
         pack_cnt_q  <= pack_cnt_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         mode_err_q  <= mode_err_d;
      end
   end

   // Output FIFO, first-word-fall-through
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic              overflow_q, pop, full, wr_en;

   assign pop   = out_valid && out_ready;
   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign wr_en = push_q && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= push_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         if (push_q && !wr_en) overflow_q <= 1'b1;
      end
   end

   assign out_valid  = (level_q != '0);
   assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_pe_result_quantizer.sv
// Directed bench for pe_result_quantizer with a queue-based reference model checked every cycle.
module tb_pe_result_quantizer;
   localparam int OUT_BIT = 24;
   localparam int DATA_BIT = 8;
   localparam int X_PE = 8;
   localparam int NE = 4;
   localparam int DEPTH = 16;
   localparam int WORD_W = DATA_BIT * X_PE * NE;
`ifdef QUANT_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         rst, in_valid, poolop, flush, out_ready;
   logic [OUT_BIT*NE*X_PE-1:0]   in_unpool;
   logic [OUT_BIT*X_PE-1:0]      in_pool;
   logic [4:0]                   shift;
   logic                         out_valid, overflow, mode_err;
   logic [WORD_W-1:0]            out_data;
   logic [4:0]                   fifo_level;

   pe_result_quantizer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .poolop(poolop), .in_unpool(in_unpool),
      .in_pool(in_pool), .shift(shift), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
      .overflow(overflow), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [WORD_W-1:0] act,
                             input logic [WORD_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: round-half-up right shift, then clamp to the output range.
   function automatic int quant(input longint x, input int sh);
      longint r;
      r = (sh == 0) ? x : ((x + (longint'(1) << (sh - 1))) >>> sh);
      if (RELU && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return int'(r);
   endfunction

   typedef struct {
      bit                v;
      bit                merr;
      logic [WORD_W-1:0] w;
   } pend_t;

   logic [WORD_W-1:0] q[$];
   pend_t d1, d2, nw;
   int    m_slot[NE][X_PE];
   int    m_cnt, pre;
   bit    m_ovf, m_merr, m_pop;

   function automatic logic [WORD_W-1:0] slots_word();
      logic [WORD_W-1:0] w;
      w = '0;
      for (int k = 0; k < NE; k++)
         for (int c = 0; c < X_PE; c++) w[(k*X_PE+c)*DATA_BIT +: DATA_BIT] = 8'(m_slot[k][c]);
      return w;
   endfunction

   task automatic clear_slots();
      for (int k = 0; k < NE; k++) for (int c = 0; c < X_PE; c++) m_slot[k][c] = 0;
      m_cnt = 0;
   endtask

   // Model: results enter a two-deep delay line, then land in the queue.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
         d1 = '{v: 1'b0, merr: 1'b0, w: '0};
         d2 = d1;
         clear_slots();
         m_ovf = 1'b0;
         m_merr = 1'b0;
      end else begin
         pre = q.size();
         m_pop = (pre > 0) && out_ready;
         if (m_pop) void'(q.pop_front());
         if (d2.v) begin
            if (pre < DEPTH || m_pop) q.push_back(d2.w);
            else m_ovf = 1'b1;
         end
         if (d1.merr) m_merr = 1'b1;
         d2 = d1;
         nw = '{v: 1'b0, merr: 1'b0, w: '0};
         if (in_valid && !poolop) begin
            nw.merr = (m_cnt != 0);
            clear_slots();
            nw.v = 1'b1;
            for (int c = 0; c < X_PE; c++)
               for (int e = 0; e < NE; e++)
                  nw.w[(c*NE+e)*DATA_BIT +: DATA_BIT] = 8'(quant(
                     longint'($signed(in_unpool[(c*NE+e)*OUT_BIT +: OUT_BIT])), int'(shift)));
         end else if (in_valid) begin
            for (int c = 0; c < X_PE; c++)
               m_slot[m_cnt][c] = quant(longint'($signed(in_pool[c*OUT_BIT +: OUT_BIT])),
                                        int'(shift));
            if (m_cnt == NE - 1 || flush) begin
               nw.v = 1'b1;
               nw.w = slots_word();
               clear_slots();
            end else begin
               m_cnt++;
            end
         end else if (flush && m_cnt != 0) begin
            nw.v = 1'b1;
            nw.w = slots_word();
            clear_slots();
         end
         d1 = nw;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("out_valid", longint'(out_valid), longint'(q.size() > 0));
         check("fifo_level", longint'(fifo_level), longint'(q.size()));
         check("overflow", longint'(overflow), longint'(m_ovf));
         check("mode_err", longint'(mode_err), longint'(m_merr));
         if (q.size() > 0) check_word("out_data", out_data, q[0]);
      end
   end

   int beat_id = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat_unpool();
      for (int c = 0; c < X_PE; c++)
         for (int e = 0; e < NE; e++)
            in_unpool[(c*NE+e)*OUT_BIT +: OUT_BIT] =
               24'(((beat_id * 7919 + c * 1543 + e * 389) % 6000) - 3000);
      beat_id++;
      poolop = 1'b0;
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic beat_pool(input int k);
      for (int c = 0; c < X_PE; c++) in_pool[c*OUT_BIT +: OUT_BIT] = 24'(10 * k + c);
      poolop = 1'b1;
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   bit drained;

   initial begin
      rst = 1'b1; in_valid = 1'b0; poolop = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_unpool = '0; in_pool = '0; shift = 5'd4;
      tick(3);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_level", longint'(fifo_level), 0);
      check("rst_overflow", longint'(overflow), 0);
      check("rst_mode_err", longint'(mode_err), 0);
      check_word("rst_out_data", out_data, '0);
      rst = 1'b0;
      tick(1);

      // Unpooled beat, shift 4, latency and hand-computed bytes
      in_unpool = '0;
      in_unpool[0*OUT_BIT +: OUT_BIT] = 24'd40;
      in_unpool[1*OUT_BIT +: OUT_BIT] = -24'sd40;
      in_unpool[2*OUT_BIT +: OUT_BIT] = 24'd7;
      in_unpool[3*OUT_BIT +: OUT_BIT] = 24'd2000;
      in_unpool[4*OUT_BIT +: OUT_BIT] = 24'd5000;
      in_unpool[5*OUT_BIT +: OUT_BIT] = -24'sd5000;
      in_unpool[6*OUT_BIT +: OUT_BIT] = 24'd8;
      in_unpool[7*OUT_BIT +: OUT_BIT] = -24'sd9;
      poolop = 1'b0; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      check("lat_t1", longint'(out_valid), 0);
      tick(1);
      check("lat_t2", longint'(out_valid), 0);
      tick(1);
      check("lat_t3", longint'(out_valid), 1);
      check("u_c0e0", longint'(out_data[7:0]), 3);
      check("u_c0e1", longint'(out_data[15:8]), RELU ? 0 : 254);
      check("u_c0e2", longint'(out_data[23:16]), 0);
      check("u_c0e3", longint'(out_data[31:24]), 125);
      check("u_c1e0_sat", longint'(out_data[39:32]), 127);
      check("u_c1e1_sat", longint'(out_data[47:40]), RELU ? 0 : 128);
      check("u_c1e3", longint'(out_data[63:56]), RELU ? 0 : 255);
      pop_one();

      // Four pooled beats, shift 0
      shift = 5'd0;
      for (int k = 0; k < 4; k++) beat_pool(k);
      tick(3);
      check("pool_level", longint'(fifo_level), 1);
      check("pool_s0c0", longint'(out_data[7:0]), 0);
      check("pool_s2c5", longint'(out_data[(2*8+5)*8 +: 8]), 25);
      check("pool_s3c7", longint'(out_data[(3*8+7)*8 +: 8]), 37);
      pop_one();

      // Two pooled beats then a standalone flush
      beat_pool(0);
      beat_pool(1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(3);
      check("flush_level", longint'(fifo_level), 1);
      check("flush_s1c2", longint'(out_data[(1*8+2)*8 +: 8]), 12);
      check("flush_upper_zero", longint'(out_data[255:128] != '0), 0);
      pop_one();

      // Three pooled beats then an unpooled beat
      shift = 5'd4;
      for (int k = 0; k < 3; k++) beat_pool(k + 4);
      beat_unpool();
      tick(3);
      check("merr_set", longint'(mode_err), 1);
      check("merr_level", longint'(fifo_level), 1);
      pop_one();
      tick(1);

      // Fill the FIFO, then push with a same-cycle pop
      for (int i = 0; i < DEPTH; i++) beat_unpool();
      tick(3);
      check("full_level", longint'(fifo_level), 16);
      beat_unpool();
      tick(1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("pushpop_level", longint'(fifo_level), 16);
      check("pushpop_no_ovf", longint'(overflow), 0);

      beat_unpool();
      tick(3);
      check("ovf_level", longint'(fifo_level), 16);
      check("ovf_set", longint'(overflow), 1);

      out_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 40 && !drained; i++) begin
         tick(1);
         if (!out_valid) drained = 1'b1;
      end
      out_ready = 1'b0;
      check("drain_done", longint'(drained), 1);
      check("drain_level", longint'(fifo_level), 0);

      // Asynchronous reset with five words buffered
      for (int i = 0; i < 5; i++) beat_unpool();
      tick(3);
      check("pre_rst_level", longint'(fifo_level), 5);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_out_valid", longint'(out_valid), 0);
      check("async_level", longint'(fifo_level), 0);
      check("async_overflow", longint'(overflow), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1);
      beat_unpool();
      tick(1);
      check("post_rst_t2", longint'(out_valid), 0);
      tick(1);
      check("post_rst_t3", longint'(out_valid), 1);
      pop_one();

      // Shift equal to OUT_BIT drives every element to zero
      shift = 5'd24;
      in_unpool = '0;
      in_unpool[0*OUT_BIT +: OUT_BIT] = 24'h7FFFFF;
      in_unpool[1*OUT_BIT +: OUT_BIT] = 24'h800000;
      in_unpool[2*OUT_BIT +: OUT_BIT] = 24'hFFFFFF;
      poolop = 1'b0; in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      tick(2);
      check("big_shift_valid", longint'(out_valid), 1);
      check_word("big_shift_zero", out_data, '0);
      pop_one();
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
